// File: rtl/regfile_mp.sv
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Parametrised multi-read-port register file with same-cycle
//             write-to-read bypass, optional hardwired zero register, a
//             hardware clear sweep after reset / on request, and a
//             per-register pending scoreboard for RAW hazard detection.
//  Ports    : clk, rst       - clock, synchronous active-high reset
//             init_req       - request a full clear sweep (RUN only)
//             ready          - high in RUN, low while clearing (registered)
//             write, wrAddr, wrData - write port
//             reserve, rsvAddr      - mark a register pending
//             rdAddr         - NUM_RD packed read addresses
//             rdData         - NUM_RD packed read data (combinational)
//             rdBusy         - per-port pending flag (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_req,
    output logic                     ready,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        wrAddr,
    input  logic [DATA_W-1:0]        wrData,
    input  logic                     reserve,
    input  logic [ADDR_W-1:0]        rsvAddr,
    input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
    output logic [NUM_RD*DATA_W-1:0] rdData,
    output logic [NUM_RD-1:0]        rdBusy
);

    localparam int       c_DEPTH  = 2 ** ADDR_W;
    localparam bit       c_ZERO   = (ZERO_REG != 0);
    localparam bit       c_BYPASS = (BYPASS != 0);

    localparam logic [0:0] c_CLEAR = 1'b0;
    localparam logic [0:0] c_RUN   = 1'b1;

    logic [0:0]        r_state_q;
    logic [0:0]        w_state_d;
    logic [ADDR_W-1:0] r_idx_q;
    logic [ADDR_W-1:0] w_idx_d;
    logic [c_DEPTH-1:0] r_pend_q;
    logic [c_DEPTH-1:0] w_pend_d;
    logic              r_ready_q;
    logic              w_ready_d;

    logic [DATA_W-1:0] r_arr_q [c_DEPTH];
    logic              w_arr_we;
    logic [ADDR_W-1:0] w_arr_addr;
    logic [DATA_W-1:0] w_arr_wdata;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_CLEAR;
            r_idx_q   <= '0;
            r_pend_q  <= '0;
            r_ready_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_idx_q   <= w_idx_d;
            r_pend_q  <= w_pend_d;
            r_ready_q <= w_ready_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_idx_d   = r_idx_q;
        case (r_state_q)
            c_CLEAR: begin
                // idx wraps back to 0 naturally after the last entry
                w_idx_d = r_idx_q + 1'b1;
                if (&r_idx_q) begin
                    w_state_d = c_RUN;
                end
            end
            c_RUN: begin
                if (init_req) begin
                    w_state_d = c_CLEAR;
                    w_idx_d   = '0;
                end
            end
            default: begin
                w_state_d = c_CLEAR;
                w_idx_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: array write port, scoreboard update, ready
    // ------------------------------------------------------------------
    always_comb begin
        w_arr_we    = 1'b0;
        w_arr_addr  = wrAddr;
        w_arr_wdata = wrData;
        w_pend_d    = r_pend_q;
        w_ready_d   = (w_state_d == c_RUN);
        case (r_state_q)
            c_CLEAR: begin
                w_arr_we    = 1'b1;
                w_arr_addr  = r_idx_q;
                w_arr_wdata = '0;
            end
            c_RUN: begin
                if (init_req) begin
                    // Write and reserve in the accepting cycle are dropped
                    w_pend_d = '0;
                end else begin
                    if (write && !(c_ZERO && (wrAddr == '0))) begin
                        w_arr_we = 1'b1;
                    end
                    if (write) begin
                        w_pend_d[wrAddr] = 1'b0;
                    end
                    // Applied after the clear so a new producer wins
                    if (reserve && !(c_ZERO && (rsvAddr == '0))) begin
                        w_pend_d[rsvAddr] = 1'b1;
                    end
                end
            end
            default: begin
                w_pend_d = '0;
            end
        endcase
    end

    assign ready = r_ready_q;

    // Storage array: no reset, contents are defined by the clear sweep
    always_ff @(posedge clk) begin
        if (w_arr_we) begin
            r_arr_q[w_arr_addr] <= w_arr_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    genvar i;
    generate
        for (i = 0; i < NUM_RD; i++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            logic              w_hit;
            logic [DATA_W-1:0] w_data;
            logic              w_busy;

            assign w_ra  = rdAddr[i*ADDR_W +: ADDR_W];
            assign w_hit = c_BYPASS && write && (wrAddr == w_ra);

            always_comb begin
                w_data = '0;
                w_busy = 1'b0;
                if ((r_state_q == c_RUN) && !(c_ZERO && (w_ra == '0))) begin
                    w_data = w_hit ? wrData : r_arr_q[w_ra];
                    // A bypassed value is available now, so no hazard
                    w_busy = r_pend_q[w_ra] & ~w_hit;
                end
            end

            assign rdData[i*DATA_W +: DATA_W] = w_data;
            assign rdBusy[i]                  = w_busy;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Self-checking bench for regfile_mp. Two instances share one
//             stimulus: one with bypass, one without. A behavioural model
//             (array of values, pending flags, run/sweep status) predicts
//             every output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    localparam int NRD   = 3;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              init_req;
    logic              write;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              reserve;
    logic [AW-1:0]     rsv_addr;
    logic [NRD*AW-1:0] rd_addr;

    logic              ready_bp, ready_nb;
    logic [NRD*DW-1:0] rd_data_bp, rd_data_nb;
    logic [NRD-1:0]    busy_bp, busy_nb;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD), .ZERO_REG(1), .BYPASS(1)) u_dut_bp (
        .clk(clk), .rst(rst), .init_req(init_req), .ready(ready_bp),
        .write(write), .wrAddr(wr_addr), .wrData(wr_data),
        .reserve(reserve), .rsvAddr(rsv_addr),
        .rdAddr(rd_addr), .rdData(rd_data_bp), .rdBusy(busy_bp)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst), .init_req(init_req), .ready(ready_nb),
        .write(write), .wrAddr(wr_addr), .wrData(wr_data),
        .reserve(reserve), .rsvAddr(rsv_addr),
        .rdAddr(rd_addr), .rdData(rd_data_nb), .rdBusy(busy_nb)
    );

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_pend [DEPTH];
    bit            m_run;
    int            m_cleared;
    int            checks = 0;
    int            errors = 0;

    function automatic void model_step();
        if (rst) begin
            m_run = 0;
            m_cleared = 0;
            foreach (m_pend[k]) m_pend[k] = 0;
        end else if (!m_run) begin
            m_mem[m_cleared] = '0;
            m_cleared++;
            if (m_cleared == DEPTH) m_run = 1;
        end else if (init_req) begin
            m_run = 0;
            m_cleared = 0;
            foreach (m_pend[k]) m_pend[k] = 0;
        end else begin
            if (write && wr_addr != 0) m_mem[wr_addr] = wr_data;
            if (write) m_pend[wr_addr] = 0;
            if (reserve && rsv_addr != 0) m_pend[rsv_addr] = 1;
        end
    endfunction

    function automatic logic [DW-1:0] exp_data(int a, bit bp);
        if (!m_run || a == 0) return '0;
        if (bp && write && int'(wr_addr) == a) return wr_data;
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(int a, bit bp);
        if (!m_run || a == 0) return 0;
        if (bp && write && int'(wr_addr) == a) return 0;
        return m_pend[a];
    endfunction

    function automatic int ra(int p);
        return int'(rd_addr[p*AW +: AW]);
    endfunction

    function automatic logic [DW-1:0] dbp(int p);
        return rd_data_bp[p*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] dnb(int p);
        return rd_data_nb[p*DW +: DW];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        rst = 0; init_req = 0; write = 0; reserve = 0;
    endtask

    task automatic set_rd_all(int a);
        for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_idle();
        wr_addr = '0; wr_data = '0; rsv_addr = '0; rd_addr = '0;
        rst = 1; tick(); rst = 0;
        for (int n = 0; n < DEPTH; n++) tick();
        for (int a = 0; a < DEPTH; a++) begin
            write = 1; wr_addr = AW'(a); wr_data = 32'hDEADBEEF; tick();
        end
        write = 0;
        rst = 1; tick(); rst = 0;
        for (int n = 0; n < DEPTH; n++) begin
            set_rd_all(n); settle();
            checks++;
            if (ready_bp !== 1'b0 || ready_nb !== 1'b0) begin
                errors++; $display("FAIL reset_ready_low cyc=%0d got %b/%b exp 0", n, ready_bp, ready_nb);
            end
            checks++;
            if (dbp(0) !== '0 || busy_bp !== '0) begin
                errors++; $display("FAIL reset_sweep_read cyc=%0d got %h busy %b exp 0", n, dbp(0), busy_bp);
            end
            tick();
        end
        settle();
        checks++;
        if (ready_bp !== 1'b1 || ready_nb !== 1'b1) begin
            errors++; $display("FAIL reset_ready_high got %b/%b exp 1", ready_bp, ready_nb);
        end
        for (int a = 0; a < DEPTH; a++) begin
            set_rd_all(a); settle();
            checks++;
            if (dbp(a % NRD) !== 32'h0 || dnb(0) !== 32'h0) begin
                errors++; $display("FAIL reset_cleared reg=%0d got %h/%h exp 0", a, dbp(a % NRD), dnb(0));
            end
        end
    endtask

    task automatic test_bypass();
        write = 1; wr_addr = 5'd5; wr_data = 32'h12345678; set_rd_all(5); settle();
        checks++;
        if (dbp(0) !== 32'h12345678) begin
            errors++; $display("FAIL bypass_same_cycle got %h exp 12345678", dbp(0));
        end
        checks++;
        if (dnb(0) !== exp_data(5, 0)) begin
            errors++; $display("FAIL nobypass_old got %h exp %h", dnb(0), exp_data(5, 0));
        end
        checks++;
        if (dbp(1) !== dbp(0) || dbp(2) !== dbp(0)) begin
            errors++; $display("FAIL bypass_dup_ports got %h %h exp %h", dbp(1), dbp(2), dbp(0));
        end
        tick(); write = 0; settle();
        checks++;
        if (dbp(0) !== 32'h12345678 || dnb(0) !== 32'h12345678) begin
            errors++; $display("FAIL write_next_cycle got %h/%h exp 12345678", dbp(0), dnb(0));
        end
    endtask

    task automatic test_zero_reg();
        write = 1; wr_addr = '0; wr_data = 32'hFFFFFFFF; set_rd_all(0); settle();
        checks++;
        if (dbp(0) !== 32'h0) begin
            errors++; $display("FAIL zero_no_bypass got %h exp 0", dbp(0));
        end
        tick(); write = 0;
        reserve = 1; rsv_addr = '0; tick(); reserve = 0; settle();
        for (int p = 0; p < NRD; p++) begin
            checks++;
            if (dbp(p) !== '0 || dnb(p) !== '0 || busy_bp[p] !== 1'b0 || busy_nb[p] !== 1'b0) begin
                errors++; $display("FAIL zero_reg port=%0d got %h/%h busy %b/%b exp 0", p, dbp(p), dnb(p), busy_bp[p], busy_nb[p]);
            end
        end
    endtask

    task automatic test_scoreboard();
        reserve = 1; rsv_addr = 5'd8; set_rd_all(8); settle();
        checks++;
        if (busy_bp[0] !== exp_busy(8, 1)) begin
            errors++; $display("FAIL sb_before got %b exp %b", busy_bp[0], exp_busy(8, 1));
        end
        tick(); reserve = 0; settle();
        checks++;
        if (busy_bp[0] !== 1'b1 || busy_nb[1] !== 1'b1) begin
            errors++; $display("FAIL sb_reserved got %b/%b exp 1", busy_bp[0], busy_nb[1]);
        end
        write = 1; wr_addr = 5'd8; wr_data = 32'hA5; settle();
        checks++;
        if (busy_bp[0] !== 1'b0 || dbp(0) !== 32'hA5) begin
            errors++; $display("FAIL sb_bypass_clear got busy %b data %h exp 0 a5", busy_bp[0], dbp(0));
        end
        checks++;
        if (busy_nb[0] !== 1'b1) begin
            errors++; $display("FAIL sb_nobypass_busy got %b exp 1", busy_nb[0]);
        end
        tick(); write = 0; settle();
        checks++;
        if (busy_bp !== '0 || busy_nb !== '0 || dnb(2) !== 32'hA5) begin
            errors++; $display("FAIL sb_retired got %b/%b data %h exp 0 a5", busy_bp, busy_nb, dnb(2));
        end
        write = 1; reserve = 1; wr_addr = 5'd8; rsv_addr = 5'd8; wr_data = 32'h5A;
        tick(); write = 0; reserve = 0; settle();
        checks++;
        if (busy_bp[0] !== 1'b1 || busy_nb[0] !== 1'b1 || dbp(0) !== 32'h5A) begin
            errors++; $display("FAIL sb_set_wins got %b/%b data %h exp 1 5a", busy_bp[0], busy_nb[0], dbp(0));
        end
        write = 1; wr_data = 32'h0; tick(); write = 0;
    endtask

    task automatic test_clear();
        for (int a = 1; a <= 4; a++) begin
            write = 1; wr_addr = AW'(a); wr_data = $urandom; tick();
        end
        write = 0; set_rd_all(3); settle();
        checks++;
        if (dbp(0) !== exp_data(3, 1)) begin
            errors++; $display("FAIL clear_prefill got %h exp %h", dbp(0), exp_data(3, 1));
        end
        init_req = 1; write = 1; wr_addr = 5'd1; wr_data = 32'h77;
        reserve = 1; rsv_addr = 5'd3;
        tick(); reserve = 0;
        for (int n = 0; n < DEPTH; n++) begin
            wr_addr = AW'($urandom_range(1, DEPTH - 1)); wr_data = $urandom;
            if (n == 3) init_req = 0;
            set_rd_all(n); settle();
            checks++;
            if (ready_bp !== 1'b0 || dbp(0) !== '0) begin
                errors++; $display("FAIL clear_sweep cyc=%0d ready %b data %h exp 0 0", n, ready_bp, dbp(0));
            end
            tick();
        end
        write = 0; settle();
        checks++;
        if (ready_bp !== 1'b1) begin
            errors++; $display("FAIL clear_ready got %b exp 1", ready_bp);
        end
        for (int a = 1; a <= 4; a++) begin
            set_rd_all(a); settle();
            checks++;
            if (dbp(1) !== 32'h0 || busy_bp[1] !== 1'b0 || dnb(2) !== 32'h0) begin
                errors++; $display("FAIL clear_result reg=%0d got %h busy %b exp 0 0", a, dbp(1), busy_bp[1]);
            end
        end
    endtask

    task automatic test_rst_mid_sweep();
        int n;
        init_req = 1; tick(); init_req = 0;
        for (int k = 0; k < 10; k++) tick();
        rst = 1; tick(); rst = 0;
        n = 0;
        while (ready_bp !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        // rst edge plus DEPTH sweep edges
        checks++;
        if (n != DEPTH) begin
            errors++; $display("FAIL rst_mid_edges got %0d exp %0d", n + 1, DEPTH + 1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            write    = 1'($urandom_range(0, 1));
            reserve  = 1'($urandom_range(0, 1));
            init_req = ($urandom_range(0, 149) == 0);
            wr_addr  = AW'($urandom_range(0, 7));
            rsv_addr = AW'($urandom_range(0, 7));
            wr_data  = $urandom;
            for (int p = 0; p < NRD; p++)
                rd_addr[p*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1)
                                                                      : $urandom_range(0, 7));
            settle();
            checks++;
            if (ready_bp !== m_run || ready_nb !== m_run) begin
                errors++; $display("FAIL rand_ready cyc=%0d got %b/%b exp %b", c, ready_bp, ready_nb, m_run);
            end
            for (int p = 0; p < NRD; p++) begin
                checks++;
                if (dbp(p) !== exp_data(ra(p), 1) || busy_bp[p] !== exp_busy(ra(p), 1)) begin
                    errors++; $display("FAIL rand_bp cyc=%0d port=%0d addr=%0d got %h/%b exp %h/%b",
                                       c, p, ra(p), dbp(p), busy_bp[p], exp_data(ra(p), 1), exp_busy(ra(p), 1));
                end
                checks++;
                if (dnb(p) !== exp_data(ra(p), 0) || busy_nb[p] !== exp_busy(ra(p), 0)) begin
                    errors++; $display("FAIL rand_nb cyc=%0d port=%0d addr=%0d got %h/%b exp %h/%b",
                                       c, p, ra(p), dnb(p), busy_nb[p], exp_data(ra(p), 0), exp_busy(ra(p), 0));
                end
            end
            tick();
        end
        set_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_clear();
        test_rst_mid_sweep();
        test_random();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
